// File: rtl/hangman_pkg.sv
// Shared types and constants for the hangman round controller.
package hangman_pkg;

  localparam int CHAR_W   = 5;
  localparam int CHAR_MAX = 25;
  localparam int N_CHARS  = CHAR_MAX + 1;

  typedef enum logic [2:0] {
    S_LOAD, S_GUESS, S_CMP, S_FILL, S_DRAW, S_WIN, S_LOSE, S_TOUT
  } state_t;

  typedef enum logic [1:0] {
    RES_NONE = 2'd0,
    RES_WIN  = 2'd1,
    RES_LOSE = 2'd2,
    RES_TOUT = 2'd3
  } result_t;

  function automatic logic char_ok(input logic [CHAR_W-1:0] c);
    return c <= CHAR_W'(CHAR_MAX);
  endfunction

endpackage

// File: rtl/hangman_turn_timer.sv
// Per-turn down-counter; expired flags the cycle on which the count runs out.
module hangman_turn_timer #(
  parameter int  TURN_CYC = 1000,
  localparam int TW       = $clog2(TURN_CYC + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic          clr,
  input  logic          en,
  output logic [TW-1:0] count,
  output logic          expired
);

  always_ff @(posedge clk) begin
    if (reset || clr)             count <= '0;
    else if (load)                count <= TW'(TURN_CYC);
    else if (en && count != '0)   count <= count - 1'b1;
  end

  // Fires while the last allowed cycle is being consumed, so the owner leaves
  // exactly TURN_CYC cycles after the reload.
  assign expired = en && (count <= TW'(1));

endmodule

// File: rtl/hangman_round_ctrl.sv
// Hangman round controller: word entry, guess comparison, reveal/miss tracking,
// per-turn timeout and rotating N-player scoring.
module hangman_round_ctrl
  import hangman_pkg::*;
#(
  parameter int  WORD_LEN   = 8,
  parameter int  MAX_MISSES = 6,
  parameter int  N_PLAYERS  = 2,
  parameter int  TURN_CYC   = 1000,
  parameter int  SCORE_W    = 4,
  localparam int AW         = $clog2(WORD_LEN),
  localparam int PW         = $clog2(N_PLAYERS),
  localparam int PTW        = $clog2(MAX_MISSES + 1),
  localparam int TW         = $clog2(TURN_CYC + 1)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         key_load,
  input  logic                         key_end,
  input  logic                         key_try,
  input  logic                         key_wipe,
  input  logic [4:0]                   key_char,
  input  logic                         fill_done,
  input  logic                         draw_done,
  output logic                         fill,
  output logic                         draw,
  output logic                         plot,
  output logic [WORD_LEN-1:0]          hit_mask,
  output logic [WORD_LEN-1:0]          revealed,
  output logic [AW:0]                  word_len,
  output logic [PTW-1:0]               part,
  output logic [TW-1:0]                time_left,
  output logic [PW-1:0]                setter,
  output logic [PW-1:0]                guesser,
  output logic [N_PLAYERS*SCORE_W-1:0] scores,
  output logic [1:0]                   result,
  output logic                         over
);

  localparam int LW = AW + 1;

  state_t state, state_n;
  result_t res_q;

  logic [WORD_LEN-1:0][CHAR_W-1:0]  word;
  logic [CHAR_W-1:0]                guess;
  logic [N_CHARS-1:0]               used;
  logic [N_PLAYERS-1:0][SCORE_W-1:0] score_q;

  logic [WORD_LEN-1:0] len_mask, hit;
  logic key_ok, all_rev, tmr_exp;
  logic tmr_load, round_clr, push, commit, wipe_end;
  logic win_ent, lose_ent, tout_ent;

  function automatic logic [PW-1:0] next_player(input logic [PW-1:0] p);
    return (p == PW'(N_PLAYERS - 1)) ? '0 : p + 1'b1;
  endfunction

  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] s);
    return (&s) ? s : s + 1'b1;
  endfunction

  assign key_ok  = char_ok(key_char);
  assign guesser = next_player(setter);
  assign scores  = score_q;
  assign result  = res_q;
  assign fill    = (state == S_FILL);
  assign draw    = (state == S_DRAW);

  // Positions beyond word_len hold stale zeros, so they are masked out of the compare.
  always_comb begin
    len_mask = '0;
    hit      = '0;
    for (int i = 0; i < WORD_LEN; i++) begin
      len_mask[i] = LW'(i) < word_len;
      hit[i]      = (word[i] == guess) && len_mask[i];
    end
  end

  assign all_rev = &(revealed | ~len_mask);

  hangman_turn_timer #(.TURN_CYC(TURN_CYC)) u_timer (
    .clk     (clk),
    .reset   (reset),
    .load    (tmr_load),
    .clr     (round_clr),
    .en      (state == S_GUESS),
    .count   (time_left),
    .expired (tmr_exp)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= S_LOAD;
    else       state <= state_n;
  end

  always_comb begin
    state_n   = state;
    tmr_load  = 1'b0;
    round_clr = 1'b0;
    push      = 1'b0;
    commit    = 1'b0;
    wipe_end  = 1'b0;
    win_ent   = 1'b0;
    lose_ent  = 1'b0;
    tout_ent  = 1'b0;
    case (state)
      S_LOAD: begin
        if (key_wipe) begin
          round_clr = 1'b1;
        end else if (key_end && word_len != '0) begin
          state_n  = S_GUESS;
          tmr_load = 1'b1;
        end else if (key_load && key_ok && word_len < LW'(WORD_LEN)) begin
          push = 1'b1;
        end
      end
      S_GUESS: begin
        if (key_wipe) begin
          state_n   = S_LOAD;
          round_clr = 1'b1;
        end else if (tmr_exp) begin
          state_n  = S_TOUT;
          tout_ent = 1'b1;
        end else if (key_try && key_ok) begin
          state_n = S_CMP;
        end
      end
      S_CMP: begin
        commit = 1'b1;
        if (used[guess]) begin
          state_n  = S_GUESS;
          tmr_load = 1'b1;
        end else if (hit != '0) begin
          state_n = S_FILL;
        end else begin
          state_n = S_DRAW;
        end
      end
      S_FILL: begin
        if (fill_done) begin
          if (all_rev) begin
            state_n = S_WIN;
            win_ent = 1'b1;
          end else begin
            state_n  = S_GUESS;
            tmr_load = 1'b1;
          end
        end
      end
      S_DRAW: begin
        if (draw_done) begin
          if (part == PTW'(MAX_MISSES)) begin
            state_n  = S_LOSE;
            lose_ent = 1'b1;
          end else begin
            state_n  = S_GUESS;
            tmr_load = 1'b1;
          end
        end
      end
      S_WIN, S_LOSE, S_TOUT: begin
        if (key_wipe) begin
          state_n   = S_LOAD;
          round_clr = 1'b1;
          wipe_end  = 1'b1;
        end
      end
      default: state_n = S_LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      word     <= '0;
      word_len <= '0;
      guess    <= '0;
      used     <= '0;
      hit_mask <= '0;
      revealed <= '0;
      part     <= '0;
      res_q    <= RES_NONE;
      setter   <= '0;
      score_q  <= '0;
      over     <= 1'b0;
      plot     <= 1'b0;
    end else begin
      over <= wipe_end;
      plot <= (state_n != S_GUESS) && (state_n != S_CMP);
      if (round_clr) begin
        word     <= '0;
        word_len <= '0;
        used     <= '0;
        hit_mask <= '0;
        revealed <= '0;
        part     <= '0;
        res_q    <= RES_NONE;
      end
      if (wipe_end) setter <= next_player(setter);
      if (push) begin
        for (int i = 0; i < WORD_LEN; i++)
          if (LW'(i) == word_len) word[i] <= key_char;
        word_len <= word_len + 1'b1;
      end
      if (state == S_GUESS && state_n == S_CMP) guess <= key_char;
      // A repeated letter refreshes hit_mask but never counts as a new miss or reveal.
      if (commit) begin
        hit_mask <= hit;
        if (!used[guess]) begin
          used[guess] <= 1'b1;
          revealed    <= revealed | hit;
          if (hit == '0) part <= part + 1'b1;
        end
      end
      if (win_ent) begin
        res_q            <= RES_WIN;
        score_q[guesser] <= sat_inc(score_q[guesser]);
      end
      if (lose_ent || tout_ent) begin
        res_q           <= lose_ent ? RES_LOSE : RES_TOUT;
        score_q[setter] <= sat_inc(score_q[setter]);
      end
    end
  end

endmodule

// File: tb/tb_hangman_round_ctrl.sv
// Randomized bench for hangman_round_ctrl against a round-level game model.
module tb_hangman_round_ctrl;

  localparam int WL = 8, MM = 6, NP = 2, TC = 10, SW = 2;
  localparam int SMAX = (1 << SW) - 1;

  logic clk = 1'b0, reset = 1'b0;
  logic key_load = 0, key_end = 0, key_try = 0, key_wipe = 0;
  logic [4:0] key_char = '0;
  logic fill_done = 0, draw_done = 0;
  logic fill, draw, plot, over;
  logic [WL-1:0] hit_mask, revealed;
  logic [3:0] word_len;
  logic [2:0] part;
  logic [3:0] time_left;
  logic [0:0] setter, guesser;
  logic [NP*SW-1:0] scores;
  logic [1:0] result;

  hangman_round_ctrl #(.WORD_LEN(WL), .MAX_MISSES(MM), .N_PLAYERS(NP),
                       .TURN_CYC(TC), .SCORE_W(SW)) dut (
    .clk(clk), .reset(reset), .key_load(key_load), .key_end(key_end),
    .key_try(key_try), .key_wipe(key_wipe), .key_char(key_char),
    .fill_done(fill_done), .draw_done(draw_done), .fill(fill), .draw(draw),
    .plot(plot), .hit_mask(hit_mask), .revealed(revealed), .word_len(word_len),
    .part(part), .time_left(time_left), .setter(setter), .guesser(guesser),
    .scores(scores), .result(result), .over(over)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;

  // game model
  int word_m[$];
  logic [WL-1:0] rev_m;
  bit used_m[26];
  int miss_m, setter_m, st;
  int sc[NP];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  function automatic logic [63:0] exp_scores();
    logic [63:0] e = '0;
    for (int p = 0; p < NP; p++) e |= 64'(sc[p]) << (p * SW);
    return e;
  endfunction

  function automatic logic [WL-1:0] len_bits();
    logic [WL-1:0] m = '0;
    for (int i = 0; i < word_m.size(); i++) m[i] = 1'b1;
    return m;
  endfunction

  task automatic clear_round();
    word_m.delete();
    rev_m  = '0;
    used_m = '{default: 0};
    miss_m = 0;
    st     = 0;
  endtask

  task automatic chk_zero();
    chk("z_fill", fill, 0);       chk("z_draw", draw, 0);
    chk("z_plot", plot, 0);       chk("z_hit", hit_mask, 0);
    chk("z_rev", revealed, 0);    chk("z_wlen", word_len, 0);
    chk("z_part", part, 0);       chk("z_tleft", time_left, 0);
    chk("z_setter", setter, 0);   chk("z_guesser", guesser, 1);
    chk("z_scores", scores, 0);   chk("z_result", result, 0);
    chk("z_over", over, 0);
  endtask

  task automatic do_reset();
    reset = 1; tick();
    chk_zero();
    reset = 0;
    clear_round();
    setter_m = 0;
    sc = '{default: 0};
  endtask

  task automatic load_word();
    key_end = 1; tick(); key_end = 0;
    chk("end_empty", plot, 1);
    for (int i = 0; i < word_m.size(); i++) begin
      if ($urandom % 4 == 0) begin
        key_load = 1; key_char = 5'(26 + $urandom % 6); tick(); key_load = 0;
        chk("bad_load", word_len, i);
      end
      key_load = 1; key_char = 5'(word_m[i]); tick(); key_load = 0;
      chk("wlen", word_len, i + 1);
    end
    if (word_m.size() == WL) begin
      key_load = 1; key_char = 5'd3; tick(); key_load = 0;
      chk("full_load", word_len, WL);
    end
    key_end = 1; tick(); key_end = 0;
    chk("entry_tleft", time_left, TC);
    chk("entry_plot", plot, 0);
  endtask

  task automatic end_state(input int r);
    if (r == 1) sc[(setter_m + 1) % NP] = (sc[(setter_m + 1) % NP] < SMAX) ? sc[(setter_m + 1) % NP] + 1 : SMAX;
    else        sc[setter_m] = (sc[setter_m] < SMAX) ? sc[setter_m] + 1 : SMAX;
    st = r;
    chk("end_result", result, r);
    chk("end_scores", scores, exp_scores());
    chk("end_plot", plot, 1);
  endtask

  // In GUESS at turn start; idle d cycles (sometimes with invalid tries), then try c.
  task automatic guess(input int c, input int d);
    int el = 0;
    logic [WL-1:0] h;
    for (int k = 0; k < d; k++) begin
      chk("tleft", time_left, TC - k);
      if ($urandom % 3 == 0) begin key_try = 1; key_char = 5'(26 + $urandom % 6); end
      tick(); key_try = 0;
      el++;
      if (el == TC) begin end_state(3); return; end
    end
    chk("try_tleft", time_left, TC - el);
    key_try = 1; key_char = 5'(c); tick(); key_try = 0;
    el++;
    if (el == TC) begin end_state(3); return; end
    tick();
    if (used_m[c]) begin
      chk("rep_fill", fill, 0); chk("rep_draw", draw, 0);
      chk("rep_part", part, miss_m); chk("rep_tleft", time_left, TC);
      return;
    end
    used_m[c] = 1;
    h = '0;
    for (int i = 0; i < word_m.size(); i++) if (word_m[i] == c) h[i] = 1'b1;
    if (h != '0) begin
      rev_m |= h;
      chk("fill", fill, 1); chk("hit_mask", hit_mask, h);
      chk("revealed", revealed, rev_m); chk("fill_plot", plot, 1);
      for (int k = $urandom % 4; k > 0; k--) begin
        tick();
        chk("fill_hold", fill, 1); chk("fill_frz", time_left, TC - el);
      end
      fill_done = 1; tick(); fill_done = 0;
      if (rev_m == len_bits()) end_state(1);
      else begin chk("fill_off", fill, 0); chk("fill_tleft", time_left, TC); end
    end else begin
      miss_m++;
      chk("draw", draw, 1); chk("part", part, miss_m); chk("miss_hit", hit_mask, 0);
      for (int k = 0; k < 3; k++) begin
        tick();
        chk("draw_hold", draw, 1); chk("draw_frz", time_left, TC - el);
      end
      draw_done = 1; tick(); draw_done = 0;
      if (miss_m == MM) end_state(2);
      else begin chk("draw_off", draw, 0); chk("draw_tleft", time_left, TC); end
    end
  endtask

  task automatic wipe_end();
    key_wipe = 1; tick(); key_wipe = 0;
    setter_m = (setter_m + 1) % NP;
    clear_round();
    chk("over", over, 1); chk("wipe_setter", setter, setter_m);
    chk("wipe_guesser", guesser, (setter_m + 1) % NP);
    chk("wipe_result", result, 0); chk("wipe_part", part, 0);
    chk("wipe_rev", revealed, 0); chk("wipe_wlen", word_len, 0);
    tick();
    chk("over_pulse", over, 0);
  endtask

  task automatic abort();
    key_wipe = 1; tick(); key_wipe = 0;
    clear_round();
    chk("abort_over", over, 0); chk("abort_wlen", word_len, 0);
    chk("abort_plot", plot, 1); chk("abort_setter", setter, setter_m);
    chk("abort_scores", scores, exp_scores());
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog checks=%0d", n_chk);
    $fatal(1, "watchdog expired");
  end

  initial begin
    #1;
    do_reset();

    // CAB -> win for player 1, then wipe rotates setter
    word_m = '{2, 0, 1};
    load_word();
    guess(0, 0);
    chk("cab_hit", hit_mask, 3'b010);
    guess(1, 1); guess(2, 0);
    chk("cab_win", result, 1);
    chk("cab_score1", scores[SW +: SW], 1);
    wipe_end();
    chk("cab_setter", setter, 1);
    // abort in GUESS keeps scores and setter
    word_m = '{4, 4};
    load_word(); guess(9, 0);
    abort();

    // "A", repeated miss, then six distinct misses -> lose
    do_reset();
    word_m = '{0};
    load_word();
    guess(5, 0); guess(5, 2);
    chk("rep_part6", part, 1);
    for (int c = 6; c < 11; c++) guess(c, 0);
    chk("lose_res", result, 2);
    chk("lose_score0", scores[0 +: SW], 1);
    wipe_end();

    // timeout exactly TC cycles after entry; try on the expiry cycle is ignored
    word_m = '{7};
    load_word(); guess(7, TC);
    wipe_end();
    word_m = '{7};
    load_word(); guess(7, TC - 1);
    chk("exp_try_tout", result, 3);
    wipe_end();

    // eight-letter word with ninth load attempt
    word_m = '{1, 2, 3, 4, 5, 6, 7, 8};
    load_word();
    for (int c = 1; c < 9 && st == 0; c++) guess(c, 0);
    wipe_end();

    // saturation: player 1 collects wins (as guesser) and timeouts (as setter)
    do_reset();
    for (int r = 0; r < 4; r++) begin
      word_m = '{3};
      load_word(); guess(3, 0); wipe_end();
      word_m = '{3};
      load_word(); guess(0, TC); wipe_end();
    end
    chk("sat_score1", scores[SW +: SW], SMAX);

    // randomized rounds
    for (int r = 0; r < 40; r++) begin
      int n;
      n = 1 + $urandom % WL;
      word_m.delete();
      for (int i = 0; i < n; i++) word_m.push_back($urandom % 6);
      load_word();
      if ($urandom % 8 == 0) begin abort(); continue; end
      for (int g = 0; g < 40 && st == 0; g++) begin
        int c, d;
        c = ($urandom % 2) ? word_m[$urandom % n] : $urandom % 9;
        d = ($urandom % 12 == 0) ? TC - 1 : (($urandom % 20 == 0) ? TC : $urandom % 3);
        guess(c, d);
      end
      if (st != 0) wipe_end(); else abort();
    end

    // reset while drawing a part
    word_m = '{0};
    load_word();
    key_try = 1; key_char = 5'd4; tick(); key_try = 0;
    tick();
    chk("pre_rst_draw", draw, 1);
    do_reset();

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
